// File: rtl/ex.sv
// MIPS32 execute stage: single-cycle logic/shift ops plus a 32-iteration
// restoring divider for DIV/DIVU that stalls the pipeline and emits HI/LO.
module ex #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_DIV   = 3'b011;

  localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    logic signed [31:0] vs;
    vs = v;
    return neg ? 32'(-vs) : v;
  endfunction

  // Two's-complement magnitude for signed DIV; DIVU operands pass untouched.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return cond_neg(v, is_signed && v[31]);
  endfunction

  logic        is_div;
  logic        is_signed;
  logic        start;
  logic [4:0]  sh;
  logic signed [31:0] r2_s;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] rem_nx;

  assign is_div    = (alusel_i == SEL_DIV) && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
  assign is_signed = (aluop_i == OP_DIV);
  assign start     = !rst && (state == IDLE) && is_div && !flush_i;
  assign sh        = reg1_i[4:0];
  assign r2_s      = reg2_i;

  always_comb begin
    logic_res = 32'd0;
    case (aluop_i)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = 32'd0;
    endcase
  end

  always_comb begin
    shift_res = 32'd0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << sh;
      OP_SRL:  shift_res = reg2_i >> sh;
      OP_SRA:  shift_res = 32'(r2_s >>> sh);
      default: shift_res = 32'd0;
    endcase
  end

  // One restoring step: shift {rem,quot} left, subtract divisor when it fits.
  assign trial  = {rem, quot[31]};
  assign ge     = trial >= {1'b0, dvs};
  assign rem_nx = ge ? (trial[31:0] - dvs) : trial[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      case (state)
        IDLE: if (is_div && !flush_i) begin
          cnt   <= 6'd0;
          state <= (reg2_i != 32'd0) ? BUSY : DONE;
        end
        BUSY: if (flush_i) begin
          state <= IDLE;
        end else begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and datapath registers carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (start) begin
      if (reg2_i != 32'd0) begin
        quot  <= magnitude(reg1_i, is_signed);
        dvs   <= magnitude(reg2_i, is_signed);
        neg_q <= is_signed && (reg1_i[31] ^ reg2_i[31]);
        neg_r <= is_signed && reg1_i[31];
      end else begin
        quot  <= 32'd0;
        dvs   <= 32'd0;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
      rem <= 32'd0;
    end else if (state == BUSY) begin
      rem  <= rem_nx;
      quot <= {quot[30:0], ge};
    end
  end

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i && (alusel_i != SEL_DIV);
      case (alusel_i)
        SEL_LOGIC: wdata_o = logic_res;
        SEL_SHIFT: wdata_o = shift_res;
        default:   wdata_o = 32'd0;
      endcase
      stallreq_o = !flush_i && (((state == IDLE) && is_div) || (state == BUSY));
      if (state == DONE) begin
        whilo_o = 1'b1;
        lo_o    = cond_neg(quot, neg_q);
        hi_o    = cond_neg(rem, neg_r);
      end
    end
  end

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage with a cycle-level reference model.
module tb_ex;
  localparam int DIV_CYCLES = 32;

  localparam logic [7:0] OP_NOP  = 8'b00000000;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;
  localparam logic [2:0] S_NOP = 3'b000, S_LOG = 3'b001, S_SH = 3'b010, S_DIV = 3'b011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = OP_NOP;
  logic [2:0]  alusel_i = S_NOP;
  logic [31:0] reg1_i = '0, reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int total = 0;
  int bad = 0;

  ex #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: divide result from plain 64-bit arithmetic, timing as a countdown.
  int          m_left = 0;
  bit          m_done = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  function automatic bit div_op();
    return (alusel_i == S_DIV) && (aluop_i == OP_DIV || aluop_i == OP_DIVU);
  endfunction

  always @(posedge clk) begin
    longint a, b, q, r;
    if (rst) begin
      m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      if (flush_i) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else if (div_op() && !flush_i) begin
      if (reg2_i == 32'd0) begin
        m_done = 1; m_hi = '0; m_lo = '0;
      end else begin
        if (aluop_i == OP_DIV) begin
          a = longint'($signed(reg1_i)); b = longint'($signed(reg2_i));
        end else begin
          a = longint'({32'd0, reg1_i}); b = longint'({32'd0, reg2_i});
        end
        q = a / b; r = a % b;
        m_lo = 32'(q); m_hi = 32'(r);
        m_left = DIV_CYCLES;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_wdata;
    logic [31:0] sh;
    sh = {27'd0, reg1_i[4:0]};
    e_wdata = '0;
    if (alusel_i == S_LOG) begin
      if (aluop_i == OP_AND) e_wdata = reg1_i & reg2_i;
      else if (aluop_i == OP_OR) e_wdata = reg1_i | reg2_i;
      else if (aluop_i == OP_XOR) e_wdata = reg1_i ^ reg2_i;
      else if (aluop_i == OP_NOR) e_wdata = ~(reg1_i | reg2_i);
    end else if (alusel_i == S_SH) begin
      if (aluop_i == OP_SLL) e_wdata = reg2_i << sh;
      else if (aluop_i == OP_SRL) e_wdata = reg2_i >> sh;
      else if (aluop_i == OP_SRA) e_wdata = 32'($signed(reg2_i) >>> sh);
    end
    if (rst) begin
      chk("m_rst_out", {wd_o, wreg_o, whilo_o, stallreq_o} | wdata_o | hi_o | lo_o, 32'd0);
    end else begin
      chk("m_wdata", wdata_o, e_wdata);
      chk("m_wd", {27'd0, wd_o}, {27'd0, wd_i});
      chk("m_wreg", {31'd0, wreg_o}, {31'd0, wreg_i && alusel_i != S_DIV});
      chk("m_stall", {31'd0, stallreq_o},
          {31'd0, !flush_i && ((m_left > 0) || (!m_done && m_left == 0 && div_op()))});
      chk("m_whilo", {31'd0, whilo_o}, {31'd0, m_done});
      chk("m_hi", hi_o, m_done ? m_hi : 32'd0);
      chk("m_lo", lo_o, m_done ? m_lo : 32'd0);
    end
  end

  task automatic drv(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] d, input logic w);
    @(posedge clk); #1;
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = d; wreg_i = w;
  endtask

  // Observe a divide from its issue cycle; when = cycle offset of whilo_o, -1 on timeout.
  task automatic div_wait(output int stalls, output int when, output logic [31:0] hi,
                          output logic [31:0] lo, output logic wr);
    stalls = 0; when = -1; hi = '0; lo = '0; wr = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (whilo_o) begin
        when = i; hi = hi_o; lo = lo_o; wr = wreg_o;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (whilo_o) pulses++;
    end
  endtask

  initial begin
    int st, wh, np;
    logic [31:0] hi, lo;
    logic wr;

    drv(OP_OR, S_LOG, 32'h0000F0F0, 32'h0F0F0000, 5'd5, 1'b1);
    @(negedge clk);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    @(negedge clk);
    chk("or_wdata", wdata_o, 32'h0F0FF0F0);
    chk("or_wreg", {31'd0, wreg_o}, 32'd1);
    chk("or_wd", {27'd0, wd_o}, 32'd5);
    chk("or_stall", {31'd0, stallreq_o}, 32'd0);

    drv(OP_SRA, S_SH, 32'd4, 32'h80000010, 5'd3, 1'b1);
    @(negedge clk); chk("sra", wdata_o, 32'hF8000001);
    drv(OP_SRL, S_SH, 32'd4, 32'h80000010, 5'd3, 1'b1);
    @(negedge clk); chk("srl", wdata_o, 32'h08000001);
    drv(OP_SLL, S_SH, 32'h00000024, 32'h00000010, 5'd3, 1'b1);
    @(negedge clk); chk("sll", wdata_o, 32'h00000100);
    drv(OP_AND, S_LOG, 32'hFF00FF00, 32'h0FF00FF0, 5'd7, 1'b0);
    @(negedge clk); chk("and", wdata_o, 32'h0F000F00);
    drv(OP_NOR, S_LOG, 32'hFF00FF00, 32'h0FF00FF0, 5'd7, 1'b1);
    @(negedge clk); chk("nor", wdata_o, 32'h000F000F);
    drv(OP_SLL, S_LOG, 32'hFFFFFFFF, 32'h1, 5'd7, 1'b1);
    @(negedge clk); chk("unk_logic", wdata_o, 32'd0);

    drv(OP_DIV, S_DIV, 32'hFFFFFFF9, 32'd2, 5'd9, 1'b1);
    div_wait(st, wh, hi, lo, wr);
    chk("div_when", wh, 33); chk("div_stalls", st, 33);
    chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_wreg", {31'd0, wr}, 32'd0);
    drv(OP_XOR, S_LOG, 32'hAAAA5555, 32'hFFFF0000, 5'd4, 1'b1);
    @(negedge clk);
    chk("b2b_xor", wdata_o, 32'h5555_5555);
    chk("b2b_stall", {31'd0, stallreq_o}, 32'd0);
    count_pulses(40, np); chk("b2b_pulses", np, 0);

    drv(OP_DIVU, S_DIV, 32'hFFFFFFFF, 32'h10, 5'd9, 1'b0);
    div_wait(st, wh, hi, lo, wr);
    chk("divu_when", wh, 33); chk("divu_stalls", st, 33);
    chk("divu_lo", lo, 32'h0FFFFFFF); chk("divu_hi", hi, 32'hF);
    drv(OP_DIVU, S_DIV, 32'h1234, 32'd0, 5'd9, 1'b0);
    div_wait(st, wh, hi, lo, wr);
    chk("div0_when", wh, 1); chk("div0_stalls", st, 1);
    chk("div0_lo", lo, 32'd0); chk("div0_hi", hi, 32'd0);

    drv(OP_DIV, S_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd9, 1'b0);
    div_wait(st, wh, hi, lo, wr);
    chk("ovf_when", wh, 33);
    chk("ovf_lo", lo, 32'h80000000); chk("ovf_hi", hi, 32'd0);

    drv(OP_DIV, S_DIV, 32'd1000, 32'hFFFFFFF9, 5'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk); chk("flush_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    aluop_i = OP_NOP; alusel_i = S_NOP;
    count_pulses(40, np); chk("flush_pulses", np, 0);

    drv(OP_DIVU, S_DIV, 32'd1000, 32'd3, 5'd9, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out", {wd_o, wreg_o, whilo_o, stallreq_o} | wdata_o | hi_o | lo_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    aluop_i = OP_NOP; alusel_i = S_NOP;
    count_pulses(40, np); chk("rst_pulses", np, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
